// File: rtl/jk_ff_checker.sv
// Online checker for a JK flip-flop: seeds a reference model from the DUT, then compares Q every edge.
// Optional macro JK_CHECK_QN_EN additionally flags edges where qn_dut is not the complement of q_dut.
module jk_ff_checker #(
  parameter int CNT_W   = 8,
  parameter int MAX_ERR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic             q_dut,
  input  logic             qn_dut,
  output logic             q_exp,
  output logic             err,
  output logic             fail,
  output logic [CNT_W-1:0] hold_cnt,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic [CNT_W-1:0] tgl_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);

  state_t           state;
  state_t           state_d;
  logic             mis;
  logic             chk;
  logic             reach;
  logic [CNT_W-1:0] err_cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic jk_next(input logic q, input logic jj, input logic kk);
    logic r;
    case ({jj, kk})
      2'b00:   r = q;
      2'b10:   r = 1'b1;
      2'b01:   r = 1'b0;
      default: r = ~q;
    endcase
    return r;
  endfunction

`ifdef JK_CHECK_QN_EN
  // A Q and a QN mismatch on the same edge fold into a single error.
  assign mis = (q_dut != q_exp) || (qn_dut != ~q_dut);
`else
  logic unused_qn;
  assign unused_qn = qn_dut;
  assign mis = (q_dut != q_exp);
`endif

  assign chk         = (state == CHECK) && en;
  assign err_cnt_inc = sat_inc(err_cnt);
  assign reach       = mis && (err_cnt_inc == MAX_ERR_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (en) state_d = SYNC;
      SYNC:    state_d = CHECK;
      CHECK: begin
        if (!en)        state_d = IDLE;
        else if (reach) state_d = FAIL;
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // q_exp is deliberately kept across clr; only counters and flags are cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_exp    <= 1'b0;
      err      <= 1'b0;
      fail     <= 1'b0;
      hold_cnt <= '0;
      set_cnt  <= '0;
      rst_cnt  <= '0;
      tgl_cnt  <= '0;
      err_cnt  <= '0;
    end else if (clr) begin
      err      <= 1'b0;
      fail     <= 1'b0;
      hold_cnt <= '0;
      set_cnt  <= '0;
      rst_cnt  <= '0;
      tgl_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      err <= chk && mis;
      if (state == SYNC) q_exp <= jk_next(q_dut, j, k);
      if (chk) begin
        q_exp <= jk_next(q_exp, j, k);
        case ({j, k})
          2'b00:   hold_cnt <= sat_inc(hold_cnt);
          2'b10:   set_cnt  <= sat_inc(set_cnt);
          2'b01:   rst_cnt  <= sat_inc(rst_cnt);
          default: tgl_cnt  <= sat_inc(tgl_cnt);
        endcase
        if (mis) err_cnt <= err_cnt_inc;
        if (reach) fail <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_ff_checker.sv
// Directed bench for jk_ff_checker: behavioural model compared every cycle plus literal expectations.
module tb_jk_ff_checker;

  localparam int MAXE = 4;
  localparam int MAXC = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, clr = 1'b0, j = 1'b0, k = 1'b0, q_dut = 1'b0;
  logic qn_bad = 1'b0;
  logic qn_dut;
  assign qn_dut = qn_bad ? q_dut : ~q_dut;

  logic       q_exp, err, fail;
  logic [7:0] hold_cnt, set_cnt, rst_cnt, tgl_cnt, err_cnt;
  logic       q_exp2, err2, fail2;
  logic [1:0] hold2, set2, rst2, tgl2, ecnt2;

  always #5 clk = ~clk;

  jk_ff_checker dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q_dut(q_dut), .qn_dut(qn_dut),
    .q_exp(q_exp), .err(err), .fail(fail), .hold_cnt(hold_cnt), .set_cnt(set_cnt),
    .rst_cnt(rst_cnt), .tgl_cnt(tgl_cnt), .err_cnt(err_cnt)
  );

  jk_ff_checker #(.CNT_W(2), .MAX_ERR(3)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q_dut(q_dut), .qn_dut(qn_dut),
    .q_exp(q_exp2), .err(err2), .fail(fail2), .hold_cnt(hold2), .set_cnt(set2),
    .rst_cnt(rst2), .tgl_cnt(tgl2), .err_cnt(ecnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit jkn(input bit q, input bit jj, input bit kk);
    if (jj && kk) return ~q;
    if (jj)       return 1'b1;
    if (kk)       return 1'b0;
    return q;
  endfunction

  function automatic int sat(input int x);
    return (x >= MAXC) ? MAXC : x + 1;
  endfunction

  // Model: phase 0 waiting for enable, 1 seeding, 2 checking, 3 failed.
  int m_phase;
  bit m_q, m_err, m_fail, m_mis;
  int m_cnt[4];
  int m_ecnt;
  int m_idx;

  assign m_idx = (j ? 1 : 0) + (k ? 2 : 0);
`ifdef JK_CHECK_QN_EN
  assign m_mis = (q_dut != m_q) || (qn_dut == q_dut);
`else
  assign m_mis = (q_dut != m_q);
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_q <= 1'b0; m_err <= 1'b0; m_fail <= 1'b0; m_ecnt <= 0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
    end else begin
      m_err <= 1'b0;
      if (clr) begin
        m_phase <= 0; m_fail <= 1'b0; m_ecnt <= 0;
        for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
      end else begin
        case (m_phase)
          0: if (en) m_phase <= 1;
          1: begin m_q <= jkn(q_dut, j, k); m_phase <= 2; end
          2: if (!en) m_phase <= 0;
             else begin
               m_cnt[m_idx] <= sat(m_cnt[m_idx]);
               m_q <= jkn(m_q, j, k);
               if (m_mis) begin
                 m_err  <= 1'b1;
                 m_ecnt <= sat(m_ecnt);
                 if (m_ecnt + 1 == MAXE) begin m_phase <= 3; m_fail <= 1'b1; end
               end
             end
          default: ;
        endcase
      end
    end
  end

  bit cmp_on = 1'b0;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_q_exp",  q_exp,    m_q);
      chk("m_err",    err,      m_err);
      chk("m_fail",   fail,     m_fail);
      chk("m_hold",   hold_cnt, m_cnt[0]);
      chk("m_set",    set_cnt,  m_cnt[1]);
      chk("m_rst",    rst_cnt,  m_cnt[2]);
      chk("m_tgl",    tgl_cnt,  m_cnt[3]);
      chk("m_errcnt", err_cnt,  m_ecnt);
    end
  end

  bit qf;

  task automatic step(input bit e, input bit jj, input bit kk, input bit qq, input bit cc);
    @(negedge clk);
    en = e; j = jj; k = kk; q_dut = qq; clr = cc;
    @(posedge clk);
    #1;
  endtask

  // Drives a correctly behaving flip-flop through one checked edge.
  task automatic fstep(input bit jj, input bit kk);
    step(1'b1, jj, kk, qf, 1'b0);
    qf = jkn(qf, jj, kk);
  endtask

  initial begin
    int exp_qn;
    cmp_on = 1'b1;
    #3;
    chk("rst_q_exp", q_exp, 0);
    chk("rst_err", err, 0);
    chk("rst_fail", fail, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_tgl", tgl_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Correct DUT through all four JK codes
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    qf = 1'b0;
    fstep(0, 0); fstep(1, 0); fstep(0, 1); fstep(1, 1); fstep(1, 1);
    chk("seq_hold", hold_cnt, 1);
    chk("seq_set", set_cnt, 1);
    chk("seq_rst", rst_cnt, 1);
    chk("seq_tgl", tgl_cnt, 2);
    chk("seq_errcnt", err_cnt, 0);

    // Stuck-at-0 under set: three mismatches
    fstep(1, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    chk("stuck_errcnt", err_cnt, 3);
    chk("stuck_fail", fail, 0);
    chk("stuck_err", err, 1);
    chk("stuck_set", set_cnt, 5);

    // Fourth mismatch enters FAIL; counters then freeze
    step(1, 1, 0, 0, 0);
    chk("fail_errcnt", err_cnt, 4);
    chk("fail_flag", fail, 1);
    repeat (3) step(1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("frz_set", set_cnt, 6);
    chk("frz_tgl", tgl_cnt, 2);
    chk("frz_hold", hold_cnt, 1);
    chk("frz_errcnt", err_cnt, 4);
    chk("frz_err", err, 0);
    chk("frz_fail", fail, 1);

    // clr leaves FAIL; clr beats a simultaneous mismatch
    step(0, 0, 0, 0, 1);
    chk("clr_fail", fail, 0);
    chk("clr_set", set_cnt, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1);
    chk("clrmis_errcnt", err_cnt, 0);
    chk("clrmis_err", err, 0);
    chk("clrmis_hold", hold_cnt, 0);
    step(1, 0, 0, 1, 0);
    chk("clr_idle_err", err, 0);
    chk("clr_idle_hold", hold_cnt, 0);

    // Disable mid-CHECK keeps counters and q_exp, re-enable reseeds
    step(1, 0, 0, 1, 0);
    qf = 1'b1;
    fstep(0, 1);
    step(0, 0, 0, 0, 0);
    chk("dis_rst", rst_cnt, 1);
    chk("dis_q_exp", q_exp, 0);
    step(0, 1, 1, 1, 0);
    chk("dis_tgl", tgl_cnt, 0);
    chk("dis_q_hold", q_exp, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    qf = 1'b1;
    fstep(1, 1);
    chk("reen_errcnt", err_cnt, 0);
    chk("reen_tgl", tgl_cnt, 1);
    chk("reen_rst", rst_cnt, 1);

    // Async reset mid-CHECK
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_tgl", tgl_cnt, 0);
    chk("arst_rst", rst_cnt, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    chk("arst_idle_tgl", tgl_cnt, 0);
    chk("arst_idle_q", q_exp, 0);

    // Saturation of a narrow counter
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    qf = 1'b0;
    repeat (5) fstep(1, 1);
    chk("sat_tgl8", tgl_cnt, 5);
    chk("sat_tgl2", tgl2, 3);
    chk("sat_err2", ecnt2, 0);

    // qn_dut equal to q_dut
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    qf = 1'b0;
    qn_bad = 1'b1;
    repeat (3) fstep(0, 0);
`ifdef JK_CHECK_QN_EN
    exp_qn = 3;
`else
    exp_qn = 0;
`endif
    chk("qn_errcnt", err_cnt, exp_qn);
    chk("qn_err", err, (exp_qn != 0) ? 1 : 0);
    qn_bad = 1'b0;
    step(0, 0, 0, 0, 0);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_ff_checker.md
JK_FF_CHECKER -- requirements
Module: jk_ff_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of every event and error counter.
REQ-002 The block SHALL have parameter MAX_ERR, default 4, giving the mismatch count at which FAIL is entered; legal range 1..2^CNT_W-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: checking enable.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear of counters and state.
REQ-007 The block SHALL have port j, input, 1 bit: J stimulus as applied to the flip-flop under test.
REQ-008 The block SHALL have port k, input, 1 bit: K stimulus as applied to the flip-flop under test.
REQ-009 The block SHALL have port q_dut, input, 1 bit: Q output of the flip-flop under test.
REQ-010 The block SHALL have port qn_dut, input, 1 bit: Q-bar output of the flip-flop under test; used only when the configuration macro is defined.
REQ-011 The block SHALL have port q_exp, output, 1 bit: reference-model Q.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle mismatch pulse.
REQ-013 The block SHALL have port fail, output, 1 bit: sticky failure flag.
REQ-014 The block SHALL have ports hold_cnt, set_cnt, rst_cnt and tgl_cnt, outputs, CNT_W bits each: counts of checked JK=00/10/01/11 edges.
REQ-015 The block SHALL have port err_cnt, output, CNT_W bits: mismatch count.

Function
REQ-016 The block SHALL implement the states IDLE, SYNC, CHECK and FAIL.
REQ-017 IDLE SHALL go to SYNC on a rising clock edge with en=1; otherwise IDLE SHALL hold, with q_exp frozen and no counting.
REQ-018 SYNC SHALL last exactly one edge: q_exp <= JK-next(q_dut, j, k), so that the model is seeded from the DUT, and the state SHALL then go to CHECK; no compare or count occurs in SYNC.
REQ-019 In CHECK, each edge SHALL compare q_dut against the current q_exp, i.e. the value predicted at the previous edge, and SHALL then apply q_exp <= JK-next(q_exp, j, k).
REQ-020 JK-next SHALL be: 00 hold, 10 set to 1, 01 clear to 0, 11 invert.
REQ-021 In CHECK, each edge SHALL increment exactly one of hold_cnt/set_cnt/rst_cnt/tgl_cnt, selected by the sampled j,k.
REQ-022 On a CHECK mismatch, err SHALL be 1 for the following cycle only and err_cnt SHALL increment, giving 1-edge latency from the sampling edge.
REQ-023 Consecutive mismatches SHALL produce err held high for consecutive cycles.
REQ-024 When err_cnt reaches MAX_ERR, on the same edge as that increment, the state SHALL go to FAIL and fail SHALL be set to 1.
REQ-025 FAIL SHALL be absorbing: all counters frozen, err=0, fail=1, exited only by rst or clr.
REQ-026 en=0 while in CHECK SHALL return the state to IDLE on the next edge, with counters and q_exp retained; re-enabling SHALL pass through SYNC again.
REQ-027 clr=1 at an edge SHALL zero all counters, err and fail and SHALL force the state to IDLE; clr SHALL have priority over en and over a simultaneous mismatch.
REQ-028 All counters SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-029 While rst=1, asynchronously: state SHALL be IDLE, q_exp=0, err=0, fail=0, and all counters SHALL be 0.
REQ-030 rst asserted mid-CHECK SHALL discard all history; after release the block SHALL wait in IDLE for en.

Configuration
REQ-031 With macro JK_CHECK_QN_EN defined, a CHECK edge SHALL also count as a mismatch when qn_dut != ~q_dut; a Q mismatch and a QN mismatch on the same edge SHALL count as one error.
REQ-032 Without JK_CHECK_QN_EN, qn_dut SHALL be ignored and no logic SHALL depend on it.

Verification
REQ-033 Scenario: rst pulse, en=1, correct DUT, j/k driven 00,10,01,11,11 -> err never asserted; hold=1, set=1, rst=1, tgl=2 counted after the SYNC edge.
REQ-034 Scenario: DUT forced to q_dut=0 while j=1,k=0 for 3 CHECK edges with MAX_ERR=4 -> err high for 3 cycles, err_cnt=3, fail=0.
REQ-035 Scenario: continue the previous scenario one more mismatching edge -> err_cnt=4, fail=1, state FAIL, counters frozen under further stimulus.
REQ-036 Scenario: clr=1 on the same edge as a mismatch -> err_cnt=0, err=0, state IDLE.
REQ-037 Scenario: CNT_W=2, 5 toggle edges -> tgl_cnt stops at 3.
REQ-038 Scenario: JK_CHECK_QN_EN defined, q_dut correct but qn_dut=q_dut -> err pulses and err_cnt increments once per edge.
